// File: rtl/wb8_pkg.sv
// Shared definitions for the 8-bit Wishbone read interconnect.
// Holds the FSM state encoding, the data value returned on an
// error-terminated transfer, and the width of the slave index.
package wb8_pkg;

  // Interconnect controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_ERROR = 2'b10
  } wb8_state_t;

  // Read data presented to the master when a transfer ends in error
  localparam logic [7:0] ERR_DATA = 8'hFF;

  // Read data presented to the master while no transfer is in flight
  localparam logic [7:0] IDLE_DATA = 8'h00;

  // Slave index width, wide enough for up to 16 slave ports
  localparam int IDX_W = 4;

endpackage

// File: rtl/wb8_addr_match.sv
// Purely combinational address decoder for wb8_interconnect.
// Ports:
//   adr       in  32      address to decode
//   idx       out IDX_W   index of the selected slave
//   valid     out 1       a slave (or a usable default slave) was selected
// Slave i matches when (adr & mask_i) == base_i; overlapping matches
// resolve to the lowest index. With no match the DEFAULT_SLAVE index is
// used, unless it is outside 0..NSLAVES-1, in which case valid is 0.
module wb8_addr_match
  import wb8_pkg::*;
#(
  parameter int                    NSLAVES       = 8,
  parameter logic [NSLAVES*32-1:0] SLAVE_BASE    = '0,
  parameter logic [NSLAVES*32-1:0] SLAVE_MASK    = '0,
  parameter int                    DEFAULT_SLAVE = 0
) (
  input  logic [31:0]      adr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  localparam bit              DEF_VALID = (DEFAULT_SLAVE >= 0) && (DEFAULT_SLAVE < NSLAVES);
  localparam logic [IDX_W-1:0] DEF_IDX  = DEF_VALID ? IDX_W'(DEFAULT_SLAVE) : {IDX_W{1'b0}};

  logic found_s;

  // Priority decode: the first (lowest) matching slave wins
  always_comb begin
    found_s = 1'b0;
    idx     = DEF_IDX;
    valid   = DEF_VALID;
    for (int i = 0; i < NSLAVES; i++) begin
      if (!found_s && ((adr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32])) begin
        found_s = 1'b1;
        idx     = IDX_W'(i);
        valid   = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/wb8_interconnect.sv
// Single-master, multi-slave 8-bit Wishbone read interconnect.
// Ports:
//   CLK_I      in   1           clock, all state on rising edge
//   RST_I      in   1           asynchronous active-low reset
//   ADR_I      in   32          master address
//   STB_I      in   1           master strobe, held until ACK_O
//   DAT_O      out  8           read data to master
//   ACK_O      out  1           transfer done
//   ERR_O      out  1           transfer ended in error (with ACK_O)
//   ERR_ADR_O  out  32          address of last error-terminated transfer
//   S_STB_O    out  NSLAVES     per-slave strobe
//   S_DAT_I    in   NSLAVES*8   per-slave read data
//   S_ACK_I    in   NSLAVES     per-slave acknowledge
// A request is decoded in IDLE (one cycle), forwarded to the selected
// slave in BUSY, and terminated either by the slave ACK, a master abort,
// or a timeout / decode miss that produces a one-cycle ERROR response.
// Write data and WE go from master to slaves directly, not through here.
module wb8_interconnect
  import wb8_pkg::*;
#(
  parameter int                    NSLAVES       = 8,
  parameter logic [NSLAVES*32-1:0] SLAVE_BASE    = '0,
  parameter logic [NSLAVES*32-1:0] SLAVE_MASK    = '0,
  parameter int                    DEFAULT_SLAVE = 0,
  parameter int                    TIMEOUT       = 255
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic [31:0]            ADR_I,
  input  logic                   STB_I,
  output logic [7:0]             DAT_O,
  output logic                   ACK_O,
  output logic                   ERR_O,
  output logic [31:0]            ERR_ADR_O,
  output logic [NSLAVES-1:0]     S_STB_O,
  input  logic [NSLAVES*8-1:0]   S_DAT_I,
  input  logic [NSLAVES-1:0]     S_ACK_I
);

  // Last counter value still allowed to wait for a slave ACK
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  wb8_state_t       state_r;
  logic [IDX_W-1:0] sel_r;
  logic [31:0]      adr_r;
  logic [15:0]      cnt_r;
  logic [31:0]      err_adr_r;

  logic [IDX_W-1:0] match_idx_s;
  logic             match_valid_s;
  logic [7:0]       sel_dat_s;
  logic             sel_ack_s;

  wb8_addr_match #(
    .NSLAVES      (NSLAVES),
    .SLAVE_BASE   (SLAVE_BASE),
    .SLAVE_MASK   (SLAVE_MASK),
    .DEFAULT_SLAVE(DEFAULT_SLAVE)
  ) u_match (
    .adr  (ADR_I),
    .idx  (match_idx_s),
    .valid(match_valid_s)
  );

  // Pick data and ACK of the latched slave; other slaves' ACKs are ignored
  always_comb begin
    sel_dat_s = IDLE_DATA;
    sel_ack_s = 1'b0;
    for (int i = 0; i < NSLAVES; i++) begin
      sel_dat_s = (sel_r == IDX_W'(i)) ? S_DAT_I[8*i +: 8] : sel_dat_s;
      sel_ack_s = (sel_r == IDX_W'(i)) ? S_ACK_I[i]        : sel_ack_s;
    end
  end

  // Controller FSM: decode, wait for slave with timeout, error response
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_r   <= ST_IDLE;
      sel_r     <= {IDX_W{1'b0}};
      adr_r     <= 32'h0000_0000;
      cnt_r     <= 16'h0000;
      err_adr_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (STB_I) begin
            sel_r   <= match_idx_s;
            adr_r   <= ADR_I;
            cnt_r   <= 16'h0000;
            state_r <= match_valid_s ? ST_BUSY : ST_ERROR;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // Abort and ACK both finish the transfer; ACK beats a coincident timeout
          if (!STB_I || sel_ack_s) begin
            state_r <= ST_IDLE;
          end else if (cnt_r == TMO_LAST) begin
            state_r <= ST_ERROR;
          end else begin
            cnt_r   <= cnt_r + 16'h0001;
          end
        end
        ST_ERROR: begin
          err_adr_r <= adr_r;
          state_r   <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Master-side response and slave strobes, derived from the current state
  always_comb begin
    ACK_O   = 1'b0;
    ERR_O   = 1'b0;
    DAT_O   = IDLE_DATA;
    S_STB_O = '0;
    case (state_r)
      ST_IDLE: begin
        ACK_O = 1'b0;
      end
      ST_BUSY: begin
        ACK_O = STB_I & sel_ack_s;
        DAT_O = sel_dat_s;
        for (int i = 0; i < NSLAVES; i++) begin
          S_STB_O[i] = STB_I & (sel_r == IDX_W'(i));
        end
      end
      ST_ERROR: begin
        ACK_O = 1'b1;
        ERR_O = 1'b1;
        DAT_O = ERR_DATA;
      end
      default: begin
        ACK_O = 1'b0;
      end
    endcase
  end

  assign ERR_ADR_O = err_adr_r;

endmodule

// File: tb/tb_wb8_interconnect.sv
// Scoreboard bench for wb8_interconnect with three slaves.
// dut1 uses DEFAULT_SLAVE=2, dut2 uses DEFAULT_SLAVE=3 (decode miss errors).
module tb_wb8_interconnect;

  localparam logic [95:0] BASE = {32'h0000_0000, 32'hFFFF_F800, 32'hFFFF_F000};
  localparam logic [95:0] MASK = {32'hFFFF_E000, 32'hFFFF_FF00, 32'hFFFF_F800};

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic [31:0] adr   = 32'h0;
  logic        stb1  = 1'b0;
  logic        stb2  = 1'b0;

  logic [7:0]  dat1, dat2;
  logic        ack1, ack2, err1, err2;
  logic [31:0] eadr1, eadr2;
  logic [2:0]  sstb1, sstb2, sack1, sack2;
  logic [23:0] sdat = {8'h7E, 8'hC3, 8'h5A};

  logic [7:0]  dly [3];
  logic [7:0]  wc1 [3];
  logic [7:0]  wc2 [3];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] dat;
    logic       err;
    int         cyc;
    logic [2:0] stb;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  wb8_interconnect #(.NSLAVES(3), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
                     .DEFAULT_SLAVE(2), .TIMEOUT(8)) dut1 (
    .CLK_I(CLK_I), .RST_I(RST_I), .ADR_I(adr), .STB_I(stb1),
    .DAT_O(dat1), .ACK_O(ack1), .ERR_O(err1), .ERR_ADR_O(eadr1),
    .S_STB_O(sstb1), .S_DAT_I(sdat), .S_ACK_I(sack1));

  wb8_interconnect #(.NSLAVES(3), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
                     .DEFAULT_SLAVE(3), .TIMEOUT(8)) dut2 (
    .CLK_I(CLK_I), .RST_I(RST_I), .ADR_I(adr), .STB_I(stb2),
    .DAT_O(dat2), .ACK_O(ack2), .ERR_O(err2), .ERR_ADR_O(eadr2),
    .S_STB_O(sstb2), .S_DAT_I(sdat), .S_ACK_I(sack2));

  always #5 CLK_I = ~CLK_I;

  always @(posedge CLK_I) cyc <= cyc + 1;

  // Slave models: slave i acks after dly[i] wait cycles of its strobe
  always @(posedge CLK_I or negedge RST_I) begin
    for (int i = 0; i < 3; i++) begin
      if (!RST_I) begin
        wc1[i] <= 8'd0;
        wc2[i] <= 8'd0;
      end else begin
        wc1[i] <= (sstb1[i] && !sack1[i]) ? wc1[i] + 8'd1 : 8'd0;
        wc2[i] <= (sstb2[i] && !sack2[i]) ? wc2[i] + 8'd1 : 8'd0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sack1[i] = sstb1[i] && (wc1[i] == dly[i]);
      sack2[i] = sstb2[i] && (wc2[i] == dly[i]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for dut1: compare every ACK against the scoreboard
  always @(negedge CLK_I) begin
    if (RST_I && ack1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1_dat", {24'h0, dat1}, {24'h0, e.dat});
        chk("dut1_err", {31'h0, err1}, {31'h0, e.err});
        chk("dut1_ack_cycle", cyc, e.cyc);
        chk("dut1_sstb_at_ack", {29'h0, sstb1}, {29'h0, e.stb});
      end
    end
  end

  // Monitor for dut2
  always @(negedge CLK_I) begin
    if (RST_I && ack2) begin
      if (q2.size() == 0) begin
        chk("dut2_unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("dut2_dat", {24'h0, dat2}, {24'h0, e.dat});
        chk("dut2_err", {31'h0, err2}, {31'h0, e.err});
        chk("dut2_ack_cycle", cyc, e.cyc);
        chk("dut2_sstb_at_ack", {29'h0, sstb2}, {29'h0, e.stb});
      end
    end
  end

  // One read on dut d; lat = BUSY cycle number of the expected ACK
  task automatic xfer(input int d, input logic [31:0] a, input logic [7:0] dat,
                      input logic err, input int lat, input logic [2:0] stb_exp);
    exp_t e;
    bit   got;
    @(posedge CLK_I); #1;
    adr = a;
    if (d == 1) stb1 = 1'b1; else stb2 = 1'b1;
    e.dat = dat; e.err = err; e.cyc = cyc + lat; e.stb = stb_exp;
    if (d == 1) q1.push_back(e); else q2.push_back(e);
    @(negedge CLK_I);
    chk("decode_cycle_sstb", {29'h0, (d == 1) ? sstb1 : sstb2}, 32'h0);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge CLK_I);
      if ((d == 1) ? ack1 : ack2) got = 1'b1;
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    @(posedge CLK_I); #1;
    stb1 = 1'b0;
    stb2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    dly[0] = 8'd0; dly[1] = 8'hFF; dly[2] = 8'd3;

    // Reset state
    repeat (3) @(negedge CLK_I);
    chk("rst_ack",   {31'h0, ack1}, 32'h0);
    chk("rst_err",   {31'h0, err1}, 32'h0);
    chk("rst_dat",   {24'h0, dat1}, 32'h0);
    chk("rst_sstb",  {29'h0, sstb1}, 32'h0);
    chk("rst_eadr",  eadr1, 32'h0);
    @(posedge CLK_I); #1;
    RST_I = 1'b1;

    // Normal accesses and decode boundaries
    xfer(1, 32'hFFFF_F004, 8'h5A, 1'b0, 1, 3'b001);
    xfer(1, 32'h1234_5678, 8'h7E, 1'b0, 4, 3'b100);
    xfer(1, 32'hFFFF_F7FF, 8'h5A, 1'b0, 1, 3'b001);
    xfer(1, 32'hFFFF_F900, 8'h7E, 1'b0, 4, 3'b100);
    // Timeout: error 8 cycles after entering BUSY
    xfer(1, 32'hFFFF_F810, 8'hFF, 1'b1, 9, 3'b000);
    @(negedge CLK_I);
    chk("err_adr_timeout", eadr1, 32'hFFFF_F810);
    // ACK on the timeout cycle wins
    dly[1] = 8'd7;
    xfer(1, 32'hFFFF_F8AA, 8'hC3, 1'b0, 8, 3'b010);
    chk("err_adr_kept", eadr1, 32'hFFFF_F810);
    dly[1] = 8'hFF;

    // Decode miss with invalid default slave
    xfer(2, 32'h1234_5678, 8'hFF, 1'b1, 1, 3'b000);
    @(negedge CLK_I);
    chk("dut2_err_adr", eadr2, 32'h1234_5678);
    xfer(2, 32'h0000_1FFF, 8'h7E, 1'b0, 4, 3'b100);
    xfer(2, 32'h0000_2000, 8'hFF, 1'b1, 1, 3'b000);
    @(negedge CLK_I);
    chk("dut2_err_adr_bound", eadr2, 32'h0000_2000);

    // Master abort in BUSY cycle 3
    @(posedge CLK_I); #1;
    adr = 32'hFFFF_F820; stb1 = 1'b1;
    repeat (3) @(posedge CLK_I);
    #1 stb1 = 1'b0;
    @(negedge CLK_I);
    chk("abort_ack",  {31'h0, ack1}, 32'h0);
    chk("abort_sstb", {29'h0, sstb1}, 32'h0);
    repeat (3) @(negedge CLK_I);
    chk("abort_no_err", {31'h0, err1}, 32'h0);
    xfer(1, 32'hFFFF_F004, 8'h5A, 1'b0, 1, 3'b001);

    // Asynchronous reset mid-BUSY
    @(posedge CLK_I); #1;
    adr = 32'hFFFF_F830; stb1 = 1'b1;
    @(negedge CLK_I);
    @(negedge CLK_I);
    chk("busy_sstb", {29'h0, sstb1}, 32'h2);
    #2 RST_I = 1'b0;
    #1;
    chk("arst_sstb", {29'h0, sstb1}, 32'h0);
    chk("arst_ack",  {31'h0, ack1}, 32'h0);
    chk("arst_err",  {31'h0, err1}, 32'h0);
    chk("arst_dat",  {24'h0, dat1}, 32'h0);
    chk("arst_eadr", eadr1, 32'h0);
    stb1 = 1'b0;
    @(negedge CLK_I); #1;
    RST_I = 1'b1;
    xfer(1, 32'h0000_0010, 8'h7E, 1'b0, 4, 3'b100);

    repeat (3) @(negedge CLK_I);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
